// File: rtl/silife_edge_link.sv
// -----------------------------------------------------------------------------
// silife_edge_link
//
// Serial edge transceiver for one side (N/E/S/W) of a cell-grid tile. It
// answers the grid controller's edge-sync protocol. During each sync window it:
//   - captures the local boundary cells plus one corner cell,
//   - shifts them out LSB-first, one bit per sync-clock rising edge,
//   - shifts the neighbour's bits in at the same time,
//   - publishes the received frame in parallel once all N = WIDTH+1 bits
//     have been exchanged.
//
// Protocol (all controller signals are asynchronous to clk):
//   - The controller raises i_sync_active_syn to open a window.
//   - This block answers by raising o_busy and driving bit 0 on
//     o_sync_out_syn.
//   - On every rising edge of i_sync_clk_syn the neighbour's bit on
//     i_sync_in_syn is taken, and the next local bit is driven one clk
//     after the edge is seen.
//   - o_busy drops when the N-th bit has been received. The controller
//     keeps the window open while o_busy is high.
//   - Dropping i_sync_active_syn before N edges aborts the frame: no
//     o_done pulse, and o_cells/o_corner keep their old value.
//   - A new frame needs active to go low and then high again.
//
// Ports:
//   clk                 system clock
//   reset_n             asynchronous active-low reset
//   i_sync_clk_syn      serial bit clock from the controller (async)
//   i_sync_active_syn   sync window from the controller (async)
//   i_sync_in_syn       serial data from the neighbour (async)
//   o_sync_out_syn      serial data to the neighbour (registered)
//   o_busy              high while an exchange is in progress
//   i_cells             local edge cells, sampled on the window-open cycle
//   i_corner            local corner cell, sent last
//   o_cells             neighbour edge cells, updated on frame completion
//   o_corner            neighbour corner cell, updated on frame completion
//   o_done              one-cycle pulse when o_cells/o_corner update
// -----------------------------------------------------------------------------
module silife_edge_link #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_sync_clk_syn,
  input  logic             i_sync_active_syn,
  input  logic             i_sync_in_syn,
  output logic             o_sync_out_syn,
  output logic             o_busy,
  input  logic [WIDTH-1:0] i_cells,
  input  logic             i_corner,
  output logic [WIDTH-1:0] o_cells,
  output logic             o_corner,
  output logic             o_done
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers.
  // Clock, active and data all go through two flops, so the data seen with a
  // detected clock edge is the value that was present at that edge.
  // The third flop on clock and active keeps the previous synced level for
  // edge detection.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] act_sync_q,  act_sync_d;
  logic [1:0] din_sync_q,  din_sync_d;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], i_sync_clk_syn};
    act_sync_d  = {act_sync_q[1:0],  i_sync_active_syn};
    din_sync_d  = {din_sync_q[0],    i_sync_in_syn};
  end

  logic sclk_rise;
  logic act_rise;
  logic act_fall;
  logic act_level;
  logic in_synced;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign act_rise  = act_sync_q[1]  & ~act_sync_q[2];
  assign act_fall  = ~act_sync_q[1] &  act_sync_q[2];
  assign act_level = act_sync_q[1];
  assign in_synced = din_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame state.
  // o_sync_out_syn always holds the bit currently on the wire. tx_sr_q holds
  // only the bits still to be sent, so the register is N-1 bits wide.
  // state_q is kept as a named enum so the FSM can be probed directly.
  // ---------------------------------------------------------------------------
  state_e           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [N-2:0]     tx_sr_q,    tx_sr_d;
  logic [N-1:0]     rx_sr_q,    rx_sr_d;
  logic             sync_out_q, sync_out_d;
  logic             busy_q,     busy_d;
  logic [WIDTH-1:0] cells_q,    cells_d;
  logic             corner_q,   corner_d;
  logic             done_q,     done_d;

  logic [N-1:0]     load_frame;

  assign load_frame = {i_corner, i_cells};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    sync_out_d = sync_out_q;
    busy_d     = busy_q;
    cells_d    = cells_q;
    corner_d   = corner_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Sync-clock edges are ignored until a window opens.
        if (act_rise) begin
          sync_out_d = load_frame[0];
          tx_sr_d    = load_frame[N-1:1];
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // An abort takes priority over a sync-clock edge in the same cycle.
        if (act_fall) begin
          busy_d     = 1'b0;
          sync_out_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (sclk_rise) begin
          rx_sr_d    = {in_synced, rx_sr_q[N-1:1]};
          sync_out_d = tx_sr_q[0];
          tx_sr_d    = tx_sr_q >> 1;
          cnt_d      = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        cells_d    = rx_sr_q[WIDTH-1:0];
        corner_d   = rx_sr_q[WIDTH];
        done_d     = 1'b1;
        busy_d     = 1'b0;
        sync_out_d = 1'b0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        // Further sync-clock edges in this window are ignored. Watching the
        // active level here (not its edge) lets a new act_rise be seen only
        // after active has really gone low.
        if (!act_level) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        busy_d     = 1'b0;
        sync_out_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      act_sync_q  <= '0;
      din_sync_q  <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      sync_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      cells_q     <= '0;
      corner_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      act_sync_q  <= act_sync_d;
      din_sync_q  <= din_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      sync_out_q  <= sync_out_d;
      busy_q      <= busy_d;
      cells_q     <= cells_d;
      corner_q    <= corner_d;
      done_q      <= done_d;
    end
  end

  assign o_sync_out_syn = sync_out_q;
  assign o_busy         = busy_q;
  assign o_cells        = cells_q;
  assign o_corner       = corner_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_silife_edge_link.sv
module tb_silife_edge_link;

  localparam int W = 4;
  localparam int N = W + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         sync_clk;
  logic         sync_active;
  logic         sync_in;
  logic         sync_out;
  logic         busy;
  logic [W-1:0] cells_in;
  logic         corner_in;
  logic [W-1:0] cells_out;
  logic         corner_out;
  logic         done;

  silife_edge_link #(.WIDTH(W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_sync_clk_syn    (sync_clk),
    .i_sync_active_syn (sync_active),
    .i_sync_in_syn     (sync_in),
    .o_sync_out_syn    (sync_out),
    .o_busy            (busy),
    .i_cells           (cells_in),
    .i_corner          (corner_in),
    .o_cells           (cells_out),
    .o_corner          (corner_out),
    .o_done            (done)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int checks = 0;
  int fails  = 0;

  logic [N-1:0] exp_q[$];     // expected received frames {corner, cells}
  logic         tx_exp_q[$];  // expected wire bit at each sync-clock rise
  bit           tx_check_en = 1'b0;

  int           done_seen     = 0;
  int           done_expected = 0;
  logic [W-1:0] model_cells   = '0;
  logic         model_corner  = 1'b0;

  // The window currently being driven, as seen by the model.
  logic [N-1:0] cur_frame;
  logic [N-1:0] cur_rx;
  int           pulses;

  logic [N-1:0] mon_exp;
  logic         mon_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got o_done=1 with cells %0h corner %0h, required no pulse",
                 cells_out, corner_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_frame", 32'({corner_out, cells_out}), 32'(mon_exp));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  always @(posedge sync_clk) begin
    if (tx_check_en) begin
      if (tx_exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL tx_underflow: sync-clock edge with no expected bit, got %0b", sync_out);
      end else begin
        mon_bit = tx_exp_q.pop_front();
        check("tx_bit", 32'(sync_out), 32'(mon_bit));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_window(input logic [W-1:0] c, input logic k);
    cur_frame   = {k, c};
    cur_rx      = '0;
    pulses      = 0;
    cells_in    = c;
    corner_in   = k;
    sync_active = 1'b1;
    wait_clk(2);
    check("busy_early", 32'(busy), 32'd0);
    wait_clk(1);
    check("busy_latency", 32'(busy), 32'd1);
    check("first_bit", 32'(sync_out), 32'(c[0]));
    wait_clk(2);
  endtask

  task automatic pulse(input logic din, input int lo, input int hi);
    sync_in = din;
    if (pulses < N) begin
      tx_exp_q.push_back(cur_frame[pulses]);
      cur_rx[pulses] = din;
    end else begin
      tx_exp_q.push_back(1'b0);
    end
    pulses++;
    if (pulses == N) begin
      exp_q.push_back(cur_rx);
      done_expected++;
      model_cells  = cur_rx[W-1:0];
      model_corner = cur_rx[W];
    end
    wait_clk(lo);
    sync_clk = 1'b1;
    wait_clk(hi);
    sync_clk = 1'b0;
  endtask

  task automatic end_window();
    sync_active = 1'b0;
    wait_clk(3);
    check("busy_after_close", 32'(busy), 32'd0);
    check("out_after_close", 32'(sync_out), 32'd0);
    check("cells_hold", 32'(cells_out), 32'(model_cells));
    check("corner_hold", 32'(corner_out), 32'(model_corner));
    wait_clk(6);
    check("done_count", 32'(done_seen), 32'(done_expected));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [4:0] basic_bits;
    int         np;

    reset_n     = 1'b0;
    sync_clk    = 1'b0;
    sync_active = 1'b0;
    sync_in     = 1'b0;
    cells_in    = '0;
    corner_in   = 1'b0;
    wait_clk(3);
    check("rst_sync_out", 32'(sync_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cells", 32'(cells_out), 32'd0);
    check("rst_corner", 32'(corner_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    wait_clk(3);
    tx_check_en = 1'b1;

    // Basic exchange: neighbour sends 0,1,1,0,1; local frame 1011 + corner 1.
    basic_bits = 5'b10110;
    start_window(4'b1011, 1'b1);
    for (int i = 0; i < N; i++) pulse(basic_bits[i], 4, 4);
    wait_clk(4);
    check("basic_cells", 32'(cells_out), 32'h6);
    check("basic_corner", 32'(corner_out), 32'd1);
    end_window();

    // Busy latency and hold with no sync clock, then close (abort path).
    start_window(W'($urandom), 1'($urandom_range(0, 1)));
    wait_clk(50);
    check("busy_hold", 32'(busy), 32'd1);
    check("cells_while_busy", 32'(cells_out), 32'h6);
    end_window();

    // Abort after 2 of 5 pulses.
    start_window(4'b1011, 1'b1);
    pulse(1'b1, 4, 4);
    pulse(1'b0, 4, 4);
    end_window();
    check("abort_cells", 32'(cells_out), 32'h6);

    // Extra sync-clock pulses in one window, then re-arm with 0001.
    start_window(W'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 7; i++) pulse(1'($urandom_range(0, 1)), 4, 4);
    end_window();
    start_window(4'b0001, 1'b0);
    for (int i = 0; i < N; i++) pulse(1'($urandom_range(0, 1)), 4, 4);
    end_window();

    // Local inputs change after the window opened; the frame must not.
    start_window(4'b1011, 1'b1);
    pulse(1'b1, 4, 4);
    cells_in  = 4'b0000;
    corner_in = 1'b0;
    for (int i = 1; i < N; i++) pulse(1'($urandom_range(0, 1)), 4, 4);
    end_window();

    // Asynchronous reset in the middle of a shift.
    start_window(W'($urandom), 1'b1);
    pulse(1'b1, 4, 4);
    pulse(1'b1, 4, 4);
    #2;
    reset_n     = 1'b0;
    sync_active = 1'b0;
    #1;
    check("mid_rst_sync_out", 32'(sync_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cells", 32'(cells_out), 32'd0);
    check("mid_rst_corner", 32'(corner_out), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    model_cells  = '0;
    model_corner = 1'b0;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(20);
    check("post_rst_done_count", 32'(done_seen), 32'(done_expected));
    check("post_rst_cells", 32'(cells_out), 32'd0);
    start_window(W'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < N; i++) pulse(1'($urandom_range(0, 1)), 4, 4);
    end_window();

    // Randomized windows: complete, overrun or aborted, with varied phases.
    for (int w = 0; w < 14; w++) begin
      start_window(W'($urandom), 1'($urandom_range(0, 1)));
      np = $urandom_range(1, N + 2);
      for (int i = 0; i < np; i++) begin
        pulse(1'($urandom_range(0, 1)), $urandom_range(4, 6), $urandom_range(4, 6));
        if (i == 0) begin
          cells_in  = W'($urandom);
          corner_in = 1'($urandom_range(0, 1));
        end
      end
      end_window();
    end

    wait_clk(10);
    check("frames_drained", 32'(exp_q.size()), 32'd0);
    check("tx_drained", 32'(tx_exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_seen), 32'(done_expected));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
